ce_drain_after_stop: RTL and testbench

CE_DRAIN_AFTER_STOP -- requirements
Module: ce_drain_after_stop

---
 rtl/ce_drain_after_stop.sv | 103 ++++++++++
 tb/tb_ce_drain_after_stop.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/ce_drain_after_stop.sv
// Clock-enable gate that, on a stop request, issues a fixed number of drain
// enables to flush a downstream pipeline, then halts until restarted.
module ce_drain_after_stop #(
    parameter int DRAIN_CYCLES = 16,
    parameter int SELF_CLOCK   = 0
) (
    input  logic CLK,
    input  logic RESET_N,
    input  logic CE,
    input  logic STOP,
    input  logic START,
    output logic CE_OUT,
    output logic DRAINING,
    output logic DONE,
    output logic DONE_PULSE
);

    localparam int CW = (DRAIN_CYCLES <= 2) ? 1 : $clog2(DRAIN_CYCLES);
    localparam logic [CW-1:0] LOAD_VAL = (DRAIN_CYCLES == 0) ? '0 : CW'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_HALT
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic            draining_q;
    logic            done_q;
    logic            done_pulse_q;
    logic            ece;

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        ece = 1'b0;
        case (state_q)
            ST_RUN:   ece = CE;
            ST_DRAIN: ece = (SELF_CLOCK != 0) ? 1'b1 : CE;
            default:  ece = 1'b0;
        endcase
    end

    // Gate with reset so nothing downstream advances while the controller is held.
    assign CE_OUT     = RESET_N & ece;
    assign DRAINING   = draining_q;
    assign DONE       = done_q;
    assign DONE_PULSE = done_pulse_q;

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // sees the pre-edge values of its peers.
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q      <= ST_RUN;
            cnt_q        <= LOAD_VAL;
            draining_q   <= 1'b0;
            done_q       <= 1'b0;
            done_pulse_q <= 1'b0;
        end else begin
            done_pulse_q <= 1'b0;
            case (state_q)
                ST_RUN: begin
                    if (STOP) begin
                        if (DRAIN_CYCLES == 0) begin
                            state_q      <= ST_HALT;
                            done_q       <= 1'b1;
                            done_pulse_q <= 1'b1;
                        end else begin
                            state_q    <= ST_DRAIN;
                            cnt_q      <= LOAD_VAL;
                            draining_q <= 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    // The counter reaching zero marks the last drain pulse, not one past it.
                    if (ece) begin
                        if (cnt_q == '0) begin
                            state_q      <= ST_HALT;
                            draining_q   <= 1'b0;
                            done_q       <= 1'b1;
                            done_pulse_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                end
                ST_HALT: begin
                    if (START) begin
                        state_q <= ST_RUN;
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q    <= ST_RUN;
                    draining_q <= 1'b0;
                    done_q     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ce_drain_after_stop.sv
// Four parameterisations share one stimulus stream; each is compared every
// cycle against a pulses-remaining model of the drain behaviour.
module tb_ce_drain_after_stop;

    localparam int NI = 4;
    localparam int NC [NI] = '{4, 4, 0, 256};
    localparam int SC [NI] = '{0, 1, 0, 0};

    logic clk = 1'b0;
    logic rst_n, ce, stop, start;
    logic [NI-1:0] ce_out, draining, done, done_pulse;

    always #5 clk = ~clk;

    ce_drain_after_stop #(.DRAIN_CYCLES(4), .SELF_CLOCK(0)) u_d4 (
        .CLK(clk), .RESET_N(rst_n), .CE(ce), .STOP(stop), .START(start),
        .CE_OUT(ce_out[0]), .DRAINING(draining[0]), .DONE(done[0]), .DONE_PULSE(done_pulse[0]));
    ce_drain_after_stop #(.DRAIN_CYCLES(4), .SELF_CLOCK(1)) u_d4s (
        .CLK(clk), .RESET_N(rst_n), .CE(ce), .STOP(stop), .START(start),
        .CE_OUT(ce_out[1]), .DRAINING(draining[1]), .DONE(done[1]), .DONE_PULSE(done_pulse[1]));
    ce_drain_after_stop #(.DRAIN_CYCLES(0), .SELF_CLOCK(0)) u_d0 (
        .CLK(clk), .RESET_N(rst_n), .CE(ce), .STOP(stop), .START(start),
        .CE_OUT(ce_out[2]), .DRAINING(draining[2]), .DONE(done[2]), .DONE_PULSE(done_pulse[2]));
    ce_drain_after_stop #(.DRAIN_CYCLES(256), .SELF_CLOCK(0)) u_d256 (
        .CLK(clk), .RESET_N(rst_n), .CE(ce), .STOP(stop), .START(start),
        .CE_OUT(ce_out[3]), .DRAINING(draining[3]), .DONE(done[3]), .DONE_PULSE(done_pulse[3]));

    // Model: 0 = running, 1 = draining with 'left' pulses still owed, 2 = halted.
    int mode [NI];
    int left [NI];
    bit just_halted [NI];
    bit model_valid = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_ce(input int k, input bit rst_n_v, input bit ce_v);
        if (!rst_n_v) return 1'b0;
        case (mode[k])
            0:       return ce_v;
            1:       return (SC[k] != 0) ? 1'b1 : ce_v;
            default: return 1'b0;
        endcase
    endfunction

    // One clock: drive inputs, compare outputs against the model, then advance the model.
    task automatic cycle(input bit rst_v, input bit ce_v, input bit stop_v, input bit start_v);
        bit e;
        rst_n = rst_v; ce = ce_v; stop = stop_v; start = start_v;
        #1;
        for (int k = 0; k < NI; k++) begin
            check($sformatf("ce_out[%0d]", k), 32'(ce_out[k]), 32'(model_ce(k, rst_v, ce_v)));
            if (model_valid) begin
                check($sformatf("draining[%0d]", k), 32'(draining[k]), 32'(mode[k] == 1));
                check($sformatf("done[%0d]", k), 32'(done[k]), 32'(mode[k] == 2));
                check($sformatf("done_pulse[%0d]", k), 32'(done_pulse[k]), 32'(just_halted[k]));
            end
        end
        for (int k = 0; k < NI; k++) begin
            e = model_ce(k, rst_v, ce_v);
            just_halted[k] = 1'b0;
            if (!rst_v) begin
                mode[k] = 0;
                left[k] = 0;
            end else begin
                case (mode[k])
                    0: if (stop_v) begin
                        if (NC[k] == 0) begin
                            mode[k] = 2;
                            just_halted[k] = 1'b1;
                        end else begin
                            mode[k] = 1;
                            left[k] = NC[k];
                        end
                    end
                    1: if (e) begin
                        left[k]--;
                        if (left[k] == 0) begin
                            mode[k] = 2;
                            just_halted[k] = 1'b1;
                        end
                    end
                    default: if (start_v) mode[k] = 0;
                endcase
            end
        end
        if (!rst_v) model_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    int n_drain, n_pulse;

    initial begin
        rst_n = 1'b0; ce = 1'b0; stop = 1'b0; start = 1'b0;
        @(negedge clk);
        cycle(0, 1, 0, 0);
        cycle(0, 1, 1, 1);
        cycle(1, 1, 0, 0);

        // Constant CE with a one-cycle STOP: four drain pulses then halt.
        cycle(1, 1, 1, 0);
        for (int i = 0; i < 8; i++) cycle(1, 1, 0, 0);
        cycle(1, 1, 0, 1);
        cycle(1, 1, 0, 0);

        // Toggling CE during drain, START attempted mid-drain.
        cycle(1, 1, 1, 0);
        n_drain = 0; n_pulse = 0;
        for (int i = 0; i < 12; i++) begin
            rst_n = 1'b1; ce = (i % 2 == 0); stop = 1'b0; start = (i == 2);
            #1;
            if (draining[0]) begin
                n_drain++;
                if (ce_out[0]) n_pulse++;
            end
            cycle(1, (i % 2 == 0), 0, (i == 2));
        end
        check("toggle_drain_len", n_drain, 7);
        check("toggle_pulses", n_pulse, 4);
        cycle(1, 0, 0, 1);

        // Reset in the middle of a long drain, then a full drain afterwards.
        cycle(1, 1, 1, 0);
        for (int i = 0; i < 100; i++) cycle(1, 1, 0, 0);
        cycle(0, 1, 0, 0);
        cycle(1, 1, 0, 0);
        cycle(1, 1, 1, 0);
        n_pulse = 0;
        for (int i = 0; i < 300; i++) begin
            rst_n = 1'b1; ce = 1'b1; stop = 1'b0; start = 1'b0;
            #1;
            if (draining[3] && ce_out[3]) n_pulse++;
            cycle(1, 1, 0, 0);
        end
        check("long_drain_pulses", n_pulse, 256);
        check("long_drain_done", 32'(done[3]), 1);
        cycle(1, 1, 0, 1);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 99) != 0), $urandom_range(0, 1) == 1,
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
